// File: rtl/lsu_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lsu_pkg : shared size encodings, FSM states and helpers for the LSU aligner
// Rev 1.0
// ---------------------------------------------------------------------------
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE0 = 3'd1,
    ST_WAIT0  = 3'd2,
    ST_ISSUE1 = 3'd3,
    ST_WAIT1  = 3'd4,
    ST_RESP   = 3'd5
  } lsu_state_t;

  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

endpackage
`default_nettype wire

// File: rtl/load_extend.sv
`default_nettype none
// ---------------------------------------------------------------------------
// load_extend : shifts the two-beat merge buffer, truncates to the access size
//               and sign/zero-extends to XLEN
// Rev 1.0
// ---------------------------------------------------------------------------
module load_extend
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2*XLEN-1:0]          merge,
  input  logic [$clog2(XLEN/8)-1:0]  off,
  input  logic [1:0]                 size,
  input  logic                       is_unsigned,
  output logic [XLEN-1:0]            rdata
);

  localparam int IW = $clog2(2*XLEN);

  logic [2*XLEN-1:0] w_shifted;
  logic [IW-1:0]     w_msb;
  logic              w_fill;

  always_comb begin
    rdata     = '0;
    w_shifted = merge >> {off, 3'b000};
    // Index of the most significant loaded bit selects the sign source.
    w_msb     = IW'((8 << size) - 1);
    w_fill    = ~is_unsigned & w_shifted[w_msb];
    for (int i = 0; i < XLEN; i++) begin
      rdata[i] = (i <= int'(w_msb)) ? w_shifted[i] : w_fill;
    end
  end

endmodule
`default_nettype wire

// File: rtl/lsu_align_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lsu_align_ctrl : MEM-stage load/store aligner with two-beat split for
//                  bus-word-crossing accesses
// Rev 1.0
// ---------------------------------------------------------------------------
module lsu_align_ctrl
  import lsu_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int ADDR_W      = 32,
  parameter bit MISALIGN_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [XLEN/8-1:0] mem_be,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata
);

  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);

  lsu_state_t        r_state, w_next;
  logic              r_live;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_size;
  logic              r_uns, r_we, r_err;
  logic [XLEN-1:0]   r_wdata, r_beat0, r_beat1;

  logic [3:0]        w_req_bytes, w_bytes;
  logic              w_capture, w_misaligned, w_illegal, w_crossing;
  logic [OW-1:0]     w_off;
  logic [ADDR_W-1:0] w_word_addr;
  logic [2*NB-1:0]   w_be_full;
  logic [2*XLEN-1:0] w_wdata_full;
  logic [XLEN-1:0]   w_load_data;

  assign w_req_bytes  = size_bytes(req_size);
  assign w_misaligned = |(req_addr[3:0] & (w_req_bytes - 4'd1));
  assign w_illegal    = ((XLEN == 32) && (req_size == SZ_D)) || (!MISALIGN_EN && w_misaligned);
  // r_live keeps req_ready low while reset is held and for the release cycle.
  assign req_ready    = r_live && (r_state == ST_IDLE);
  assign w_capture    = req_valid && req_ready;

  assign w_off        = r_addr[OW-1:0];
  assign w_bytes      = size_bytes(r_size);
  assign w_crossing   = (32'(w_off) + 32'(w_bytes)) > 32'(NB);
  assign w_word_addr  = {r_addr[ADDR_W-1:OW], {OW{1'b0}}};
  assign w_wdata_full = {{XLEN{1'b0}}, r_wdata} << {w_off, 3'b000};

  always_comb begin
    w_be_full = '0;
    for (int i = 0; i < 2*NB; i++) begin
      w_be_full[i] = (i >= int'(w_off)) && (i < int'(w_off) + int'(w_bytes));
    end
  end

  load_extend #(.XLEN(XLEN)) u_load_extend (
    .merge       ({r_beat1, r_beat0}),
    .off         (w_off),
    .size        (r_size),
    .is_unsigned (r_uns),
    .rdata       (w_load_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_live  <= 1'b0;
      r_addr  <= '0;
      r_size  <= '0;
      r_uns   <= 1'b0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_wdata <= '0;
      r_beat0 <= '0;
      r_beat1 <= '0;
    end else begin
      r_live  <= 1'b1;
      r_state <= w_next;
      if (w_capture) begin
        r_addr  <= req_addr;
        r_size  <= req_size;
        r_uns   <= req_unsigned;
        r_we    <= req_we;
        r_err   <= w_illegal;
        r_wdata <= req_wdata;
        r_beat0 <= '0;
        r_beat1 <= '0;
      end
      if (r_state == ST_WAIT0 && mem_rvalid) r_beat0 <= mem_rdata;
      if (r_state == ST_WAIT1 && mem_rvalid) r_beat1 <= mem_rdata;
    end
  end

  always_comb begin
    w_next    = r_state;
    mem_req   = 1'b0;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_wdata = '0;
    rsp_valid = 1'b0;
    rsp_rdata = '0;
    rsp_err   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_capture) w_next = w_illegal ? ST_RESP : ST_ISSUE0;
      end
      ST_ISSUE0: begin
        mem_req   = 1'b1;
        mem_addr  = w_word_addr;
        mem_we    = r_we;
        mem_be    = w_be_full[NB-1:0];
        mem_wdata = r_we ? w_wdata_full[XLEN-1:0] : '0;
        if (mem_gnt) w_next = ST_WAIT0;
      end
      ST_WAIT0: begin
        if (mem_rvalid) w_next = w_crossing ? ST_ISSUE1 : ST_RESP;
      end
      ST_ISSUE1: begin
        mem_req   = 1'b1;
        mem_addr  = w_word_addr + ADDR_W'(NB);
        mem_we    = r_we;
        mem_be    = w_be_full[2*NB-1:NB];
        mem_wdata = r_we ? w_wdata_full[2*XLEN-1:XLEN] : '0;
        if (mem_gnt) w_next = ST_WAIT1;
      end
      ST_WAIT1: begin
        if (mem_rvalid) w_next = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = r_err;
        rsp_rdata = (r_we || r_err) ? '0 : w_load_data;
        w_next    = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: doc/lsu_align_ctrl.md
Name: lsu_align_ctrl

Overview:
Parametrised load/store alignment controller for the MEM stage. It sits between the pipeline's memory-access request and the data-memory bus port, and generalises the combinational load aligner to XLEN 32/64. It adds store byte-lane alignment and byte-enable generation, and a sequential two-beat split for accesses that straddle a bus word. Loads are merged, sign/zero-extended and returned through a valid/ready handshake.

Parameters:
XLEN, 32, data/bus width in bits; legal values 32 or 64.
ADDR_W, 32, byte-address width.
MISALIGN_EN, 1, 1 = split word-crossing accesses into two beats; 0 = flag them as errors with no bus traffic.

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
req_valid  in  1  access request from the pipeline
req_ready  out  1  controller can accept a request (high only in IDLE)
req_we  in  1  1 = store, 0 = load
req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = double (double legal only when XLEN=64)
req_unsigned  in  1  zero-extend the load result (LBU/LHU/LWU)
req_addr  in  ADDR_W  byte address
req_wdata  in  XLEN  store data, right-justified
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  XLEN  extended load data; 0 for stores and errors
rsp_err  out  1  misaligned access with MISALIGN_EN=0, or illegal size; qualified by rsp_valid
mem_req  out  1  bus request
mem_gnt  in  1  bus accepted the request this cycle
mem_addr  out  ADDR_W  word-aligned bus address
mem_we  out  1  bus write enable
mem_be  out  XLEN/8  byte enables
mem_wdata  out  XLEN  lane-aligned write data
mem_rvalid  in  1  read data or write acknowledge valid
mem_rdata  in  XLEN  bus read data

Behaviour:
- Reset values: req_ready=0 while in reset, then 1 in IDLE. rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0. All state registers clear.
- Definitions: NB = XLEN/8; off = addr mod NB; bytes = 1<<size.
- An access is crossing if off+bytes > NB. It is misaligned if addr mod bytes != 0.
- Capture: a request is captured when req_valid && req_ready. Address, size, unsigned flag and store data are registered.
- FSM states: IDLE, ISSUE0, WAIT0, ISSUE1, WAIT1, RESP.
- IDLE -> ISSUE0 on capture. IDLE -> RESP (rsp_err=1) when the request is illegal:
  - size=3 with XLEN=32, or
  - misaligned with MISALIGN_EN=0.
- ISSUE0: mem_req=1, mem_addr = addr with the low log2(NB) bits cleared. mem_req, mem_addr, mem_we, mem_be and mem_wdata stay stable until mem_gnt. On gnt -> WAIT0.
- WAIT0: on mem_rvalid, latch mem_rdata into beat0. Then go to ISSUE1 if crossing, else RESP.
- ISSUE1 and WAIT1 behave as ISSUE0 and WAIT0. The address is the word address + NB, modulo 2^ADDR_W (wraps to 0 at the top). The latched beat is beat1. WAIT1 -> RESP.
- RESP: rsp_valid=1 for exactly one cycle, then -> IDLE.
  - Load data: {beat1, beat0} >> (8*off), truncated to bytes, then sign- or zero-extended to XLEN.
- Store lanes:
  - be_full = ((1<<bytes)-1) << off, 2*NB bits wide; beat0 uses the low NB bits, beat1 the high NB bits.
  - wdata_full = req_wdata << (8*off), 2*XLEN bits wide, split the same way.
  - Unused lanes drive 0.
- mem_rvalid outside WAIT0/WAIT1 is ignored. mem_gnt outside ISSUE states is ignored.
- Latency with gnt the same cycle and rvalid the next cycle:
  - Aligned access: capture at cycle 0, ISSUE0 at cycle 1, rvalid at cycle 2, rsp_valid at cycle 3.
  - Crossing access: rsp_valid at cycle 5.
  - Error: rsp_valid at cycle 1.
- Reset mid-operation: asynchronously returns to IDLE. mem_req drops immediately, no rsp_valid is issued, and partial beats are discarded.

Decomposition:
- Package lsu_pkg holds:
  - size encodings SZ_B/SZ_H/SZ_W/SZ_D;
  - the state enum lsu_state_t;
  - a function for the bytes-from-size calculation.
- One natural sub-module, load_extend: a combinational shift, truncate and sign/zero-extend of the 2*XLEN merge buffer. It is the generalised successor of the existing aligner.

Test Plan:
- XLEN=32, LB at 0x103, mem word 0x80FF1234 -> one beat, mem_addr 0x100, rsp_rdata 0xFFFFFF80, rsp_valid at cycle 3.
- LHU at 0x1003, beat0 @0x1000 = 0xAABBCCDD, beat1 @0x1004 = 0x11223344 -> two beats, rsp_rdata 0x000044AA.
- SW 0xDEADBEEF at 0x2002 -> beat0 addr 0x2000, be 4'b1100, wdata 0xBEEF0000; beat1 addr 0x2004, be 4'b0011, wdata 0x0000DEAD.
- MISALIGN_EN=0, LW at 0x0006 -> no mem_req, rsp_valid+rsp_err at cycle 1, rsp_rdata 0. Also LD with XLEN=32 -> rsp_err.
- mem_gnt held low 4 cycles during ISSUE0 -> mem_req/addr/be/wdata stable every cycle; req_ready stays 0 throughout.
- XLEN=64, LW at 0xFFFFFFFE (top of space) -> beat1 addr wraps to 0x0. Separately, assert rst_n low during WAIT1 -> mem_req=0 immediately, no rsp_valid, req_ready=1 after release.
